// File: rtl/temp_msg_pkg.sv
// Shared types and constants for the temperature message sequencer.
package temp_msg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CONV,
        WR_FT,
        WR_FO,
        WR_CT,
        WR_CO,
        RD_ISSUE,
        RD_WAIT,
        SEND,
        FINISH
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] NUL        = 8'h00;
    localparam logic [7:0] DIGIT_SAT  = 8'h39;

    localparam int F_TENS_ADDR_DEFAULT = 28;
    localparam int C_TENS_ADDR_DEFAULT = 34;

    // Anything above 99 F cannot be shown in two digits, so clamp it here.
    function automatic logic [6:0] to_fahrenheit(input logic [6:0] c);
        logic [10:0] f;
        f = ({4'd0, c} * 11'd9) / 11'd5 + 11'd32;
        return (f > 11'd99) ? 7'd99 : f[6:0];
    endfunction

endpackage

// File: rtl/temp_message_sequencer_bin_to_ascii2.sv
// Two-digit decimal ASCII conversion of a 7-bit value, saturating at "99".
module bin_to_ascii2
    import temp_msg_pkg::*;
(
    input  logic [6:0] value,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [7:0] wide;

    always_comb begin
        wide = {1'b0, value};
        tens = ASCII_ZERO + wide / 8'd10;
        ones = ASCII_ZERO + wide % 8'd10;
        if (value > 7'd99) begin
            tens = DIGIT_SAT;
            ones = DIGIT_SAT;
        end
    end

endmodule

// File: rtl/temp_message_sequencer.sv
// Owns the message RAM port: patches temperature digits on each sample and
// streams the NUL-terminated message to the UART on request.
module temp_message_sequencer
    import temp_msg_pkg::*;
#(
    parameter int DataWidth   = 8,
    parameter int AddressBits = 7,
    parameter int MemorySize  = 100,
    parameter int F_TENS_ADDR = F_TENS_ADDR_DEFAULT,
    parameter int C_TENS_ADDR = C_TENS_ADDR_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   temp_valid,
    input  logic [6:0]             temp_c,
    input  logic                   print_req,
    output logic                   ram_write_or_read,
    output logic [AddressBits:0]   ram_address,
    output logic [DataWidth-1:0]   ram_din,
    input  logic [DataWidth-1:0]   ram_dout,
    output logic [DataWidth-1:0]   tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);

    localparam logic [AddressBits:0] F_T      = (AddressBits + 1)'(F_TENS_ADDR);
    localparam logic [AddressBits:0] C_T      = (AddressBits + 1)'(C_TENS_ADDR);
    localparam logic [AddressBits:0] LAST_PTR = (AddressBits + 1)'(MemorySize - 1);

    state_t               state;
    logic [6:0]           sample;
    logic [6:0]           pend_sample;
    logic                 pend_sample_vld;
    logic                 pend_print;
    logic [AddressBits:0] ptr;
    logic [6:0]           f_value;
    logic [7:0]           f_tens, f_ones, c_tens, c_ones;
    logic [7:0]           f_ones_q, c_tens_q, c_ones_q;
    logic                 take_print;

    assign f_value = to_fahrenheit(sample);

    bin_to_ascii2 u_c_digits (.value(sample),  .tens(c_tens), .ones(c_ones));
    bin_to_ascii2 u_f_digits (.value(f_value), .tens(f_tens), .ones(f_ones));

    assign busy = (state != IDLE);

    // A sample always beats a print request arriving in the same IDLE cycle.
    assign take_print = (state == IDLE) && !(temp_valid || pend_sample_vld)
                        && (print_req || pend_print);

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            pend_sample_vld   <= 1'b0;
            pend_print        <= 1'b0;
            ptr               <= '0;
            ram_write_or_read <= 1'b0;
            ram_address       <= '0;
            ram_din           <= '0;
            tx_data           <= '0;
            tx_valid          <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;

            if (temp_valid && state != IDLE) begin
                pend_sample     <= temp_c;
                pend_sample_vld <= 1'b1;
            end
            if (print_req && !take_print) begin
                pend_print <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (temp_valid || pend_sample_vld) begin
                        sample          <= temp_valid ? temp_c : pend_sample;
                        pend_sample_vld <= 1'b0;
                        state           <= CONV;
                    end else if (print_req || pend_print) begin
                        pend_print  <= 1'b0;
                        ptr         <= '0;
                        ram_address <= '0;
                        state       <= RD_ISSUE;
                    end
                end
                // Write outputs are registered, so each WR_* state preloads the next write.
                CONV: begin
                    f_ones_q          <= f_ones;
                    c_tens_q          <= c_tens;
                    c_ones_q          <= c_ones;
                    ram_write_or_read <= 1'b1;
                    ram_address       <= F_T;
                    ram_din           <= DataWidth'(f_tens);
                    state             <= WR_FT;
                end
                WR_FT: begin
                    ram_address <= F_T + 1'b1;
                    ram_din     <= DataWidth'(f_ones_q);
                    state       <= WR_FO;
                end
                WR_FO: begin
                    ram_address <= C_T;
                    ram_din     <= DataWidth'(c_tens_q);
                    state       <= WR_CT;
                end
                WR_CT: begin
                    ram_address <= C_T + 1'b1;
                    ram_din     <= DataWidth'(c_ones_q);
                    state       <= WR_CO;
                end
                WR_CO: begin
                    ram_write_or_read <= 1'b0;
                    state             <= IDLE;
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (ram_dout == DataWidth'(NUL)) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        tx_data  <= ram_dout;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (ptr == LAST_PTR) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            ptr         <= ptr + 1'b1;
                            ram_address <= ptr + 1'b1;
                            state       <= RD_ISSUE;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/temp_message_sequencer.md
Name: temp_message_sequencer

Overview:
Controller that owns the single port of the temperature message RAM (8-bit data, 8-bit address, synchronous read/write, message NUL-terminated). It patches new Celsius and Fahrenheit ASCII digits into the message whenever a sensor sample arrives. On request it streams the message from address 0 up to the NUL, byte by byte, to the UART transmitter over a valid/ready handshake. It sits between the TMP101 reader, the RAM, and the UART TX.

Parameters:
DataWidth, 8, RAM data width and TX byte width
AddressBits, 7, RAM address port is AddressBits+1 bits wide
MemorySize, 100, number of RAM words; hard stop for readout
F_TENS_ADDR, 28, RAM address of Fahrenheit tens digit (ones at +1)
C_TENS_ADDR, 34, RAM address of Celsius tens digit (ones at +1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
temp_valid  in  1  one-cycle strobe: temp_c holds a new sample
temp_c  in  7  unsigned Celsius, 0..127
print_req  in  1  one-cycle strobe: transmit the message
ram_write_or_read  out  1  1 = write, 0 = read
ram_address  out  AddressBits+1  RAM address
ram_din  out  DataWidth  RAM write data
ram_dout  in  DataWidth  RAM read data, valid the cycle after the read is issued
tx_data  out  DataWidth  byte to UART
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  UART accepts byte when tx_valid & tx_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a transmission ends

Behaviour:
- Reset: state IDLE; all outputs 0 (ram_write_or_read=0, ram_address=0, tx_valid=0, busy=0, done=0); pending flags cleared. Reset mid-operation aborts immediately; no partial byte is presented afterwards.
- Conversion: F = floor(C*9/5) + 32. If C > 99, Celsius digits saturate to "99". If F > 99 (C >= 38), Fahrenheit digits saturate to "99". Digit ASCII = 8'h30 + value. Tens digit is written even when it is 0 ("05").
- States: IDLE, CONV, WR_FT, WR_FO, WR_CT, WR_CO, RD_ISSUE, RD_WAIT, SEND, FINISH.
- IDLE: if temp_valid or a sample is pending, go to CONV. Otherwise, if print_req or a print is pending, reset the pointer to 0 and go to RD_ISSUE. A sample has priority when both are present in the same cycle.
- CONV: register the four ASCII digits, 1 cycle.
- WR_*: one write per cycle, ram_write_or_read=1, to addresses F_TENS, F_TENS+1, C_TENS, C_TENS+1. Then return to IDLE. Update latency from strobe to last write is 6 cycles.
- RD_ISSUE: ram_address=ptr, ram_write_or_read=0. Go to RD_WAIT.
- RD_WAIT: sample ram_dout. If it is 8'h00, go to FINISH. Otherwise latch it into tx_data, assert tx_valid, and go to SEND.
- SEND: hold tx_data and tx_valid until tx_ready. On the handshake, deassert tx_valid, ptr++, and go to RD_ISSUE. If ptr+1 == MemorySize, go to FINISH instead (missing-NUL guard).
- FINISH: done=1 for one cycle, then IDLE.
- Pending requests while busy:
  - temp_valid: capture temp_c into a one-deep pending register; the latest sample wins.
  - print_req: set a one-deep pending flag; duplicate requests coalesce.
- A sample that arrives during a transmission is applied only after FINISH, so a transmitted message is never torn.
- ram_write_or_read is 0 in every state other than WR_*. RAM writes never occur outside WR_*.
- Throughput: at most one byte per 3 cycles when tx_ready is held high.

Decomposition:
- Package temp_msg_pkg holds:
  - the state enum;
  - ASCII_ZERO=8'h30, NUL=8'h00, DIGIT_SAT=8'h39;
  - the default digit-address constants.
- Sub-module bin_to_ascii2 (combinational): 7-bit value to two ASCII digits, saturating at 99. It is instantiated twice, once for C and once for F.

Test Plan:
- After reset, pulse print_req with tx_ready=1 -> power-up message streamed: first byte 8'h0A, 8'h0D, ..., "32" at bytes 28-29, "00" at 34-35, CR LF at 39-40; done pulses once; 41 bytes total.
- temp_valid with temp_c=25, then print_req -> bytes 28/29 = "7","7" and 34/35 = "2","5"; writes observed only at addresses 28, 29, 34, 35.
- temp_c=37 -> "98"/"37". temp_c=38 -> "99"/"38". temp_c=120 -> "99"/"99". temp_c=0 -> "32"/"00".
- Back-pressure: tx_ready low for 10 cycles on byte 4 -> tx_data and tx_valid stable throughout; no byte is skipped or duplicated.
- temp_valid(20) then temp_valid(30) during a transmission -> the in-flight message is unchanged; after done the RAM holds "86"/"30"; two print_reqs while busy yield exactly one further transmission.
- Assert reset during SEND -> next cycle tx_valid=0, busy=0; a following print_req restarts from address 0 with restored RAM content.
